jtframe_dtack_ctrl: RTL and testbench
=====================================

// Module: jtframe_dtack_ctrl
// PURPOSE
//  Parametrised 68000 DTACKn generator for JTFRAME CPU glue. Enforces a minimum
//  wait per bus cycle in cpu_cen ticks and stretches the cycle while any of NCH
//  SDRAM-backed channels is not ready. Counts the clk cycles lost to SDRAM
//  latency and recovers them on later cycles, so average CPU speed matches the
//  original hardware. Sits between the address decoder and the fx68k DTACKn input.
// PARAMETERS
//  NCH      2   number of slow (SDRAM) chip-select channels
//  MINWAIT  2   cpu_cen ticks from ASn fall before DTACKn may assert (1..7)
//  CNTW     16  width of the lost-cycle counter
// PORTS
//  clk       in   1      system clock
//  rst       in   1      synchronous reset, active high
//  cpu_cen   in   1      CPU clock enable (phi1)
//  ASn       in   1      CPU address strobe
//  bus_cs    in   NCH    registered chip selects of slow channels
//  bus_ok    in   NCH    per-channel data-ready from SDRAM controller
//  frame     in   1      one-clk pulse per frame (LVBL falling edge)
//  DTACKn    out  1      to CPU
//  fail_cnt  out  CNTW   current accumulated delay, in clk cycles
//  last_fail out  CNTW   fail_cnt captured at the last frame pulse
// BEHAVIOUR
//  Reset: DTACKn=1, fail_cnt=0, last_fail=0, wait counter wcnt=MINWAIT, last_ASn=1.
//  sel = |bus_cs ; busy = |(bus_cs & ~bus_ok) ; done = (wcnt==0).
//  Cycle start: when ASn=1, or ASn=0 with last_ASn=1: DTACKn<=1, wcnt<=MINWAIT.
//    No other rule acts on that clk.
//  While ASn=0 (after start): on each cpu_cen, wcnt<=wcnt-1 if wcnt!=0.
//  sel=0: DTACKn<=0 on the 2nd clk of ASn low; no wait, counters untouched.
//  sel=1:
//    - busy & done: fail_cnt<=fail_cnt+1 each clk; saturates at all ones.
//    - !busy & done: DTACKn<=0.
//    - !busy & wcnt==1 & fail_cnt!=0 (early recovery): DTACKn<=0,
//      fail_cnt<=fail_cnt-1. At most one recovery per bus cycle.
//  DTACKn stays 0 until ASn rises; it is 1 on the clk after ASn rises.
//  bus_ok changes after DTACKn=0 are ignored.
//  frame pulse: last_fail<=fail_cnt, fail_cnt<=0. Takes priority over inc/dec
//    in the same clk.
//  ASn rising in the same clk as a DTACKn assertion: rising edge wins, DTACKn=1.
//  rst mid-cycle: all state returns to reset values on the next clk edge.
//    The next ASn low is treated as a new cycle start.
//  Latency: with no SDRAM stall, DTACKn falls on the first clk where wcnt==0,
//    i.e. MINWAIT cpu_cen ticks after the cycle start.
// CONFIGURATION
//  JTFRAME_DTACK_RECOVER_EN defined: early-recovery rule active, as above.
//  Undefined: early-recovery rule removed. fail_cnt still increments and is still
//    captured/cleared by frame, but never decrements. DTACKn only on !busy & done.
// TESTING
//  1 sel=0, ASn low for 10 clks -> DTACKn=0 at clk 2 of ASn low; fail_cnt stays 0.
//  2 MINWAIT=2, cpu_cen every 2nd clk, bus_cs=01, bus_ok=1 -> DTACKn=0 exactly
//    when wcnt reaches 0; fail_cnt=0.
//  3 bus_cs=10, bus_ok[1] low 5 clks past done -> DTACKn held until bus_ok=1;
//    fail_cnt=5.
//  4 fail_cnt=3, four no-stall cycles with RECOVER_EN -> each cycle acks one clk
//    early; fail_cnt 3->2->1->0, 4th cycle normal. Without RECOVER_EN -> stays 3.
//  5 frame pulse while fail_cnt=7 and a stall increments the same clk ->
//    last_fail=7, fail_cnt=0.
//  6 rst asserted with DTACKn=0 and fail_cnt=4 -> next clk DTACKn=1, fail_cnt=0,
//    last_fail=0.
//  7 CNTW=4, 20-clk stall -> fail_cnt saturates at 15.

Source files
------------

// File: rtl/jtframe_dtack_ctrl.sv
// 68000 DTACKn generator: minimum wait in cpu_cen ticks, SDRAM stall stretching,
// and lost-cycle bookkeeping. Define JTFRAME_DTACK_RECOVER_EN to enable early recovery.
module jtframe_dtack_ctrl #(
  parameter int NCH     = 2,
  parameter int MINWAIT = 2,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_cen,
  input  logic            ASn,
  input  logic [NCH-1:0]  bus_cs,
  input  logic [NCH-1:0]  bus_ok,
  input  logic            frame,
  output logic            DTACKn,
  output logic [CNTW-1:0] fail_cnt,
  output logic [CNTW-1:0] last_fail
);

  localparam logic [2:0] WAIT_INIT = 3'(MINWAIT);

  logic [2:0] wcnt;
  logic       last_ASn;
  logic       sel, busy, done, cycle_start, recover;

  assign sel         = |bus_cs;
  assign busy        = |(bus_cs & ~bus_ok);
  assign done        = (wcnt == 3'd0);
  assign cycle_start = ASn | last_ASn;

`ifdef JTFRAME_DTACK_RECOVER_EN
  // Pay back one lost clk by acking one tick before the minimum wait expires.
  assign recover = !busy && (wcnt == 3'd1) && (fail_cnt != '0);
`else
  assign recover = 1'b0;
`endif

  // NOTE: every register here is written with <= so all updates see the values
  // from before the edge; the frame clear is placed last so it overrides inc/dec.
  always_ff @(posedge clk) begin
    if (rst) begin
      DTACKn    <= 1'b1;
      fail_cnt  <= '0;
      last_fail <= '0;
      wcnt      <= WAIT_INIT;
      last_ASn  <= 1'b1;
    end else begin
      last_ASn <= ASn;
      if (cycle_start) begin
        DTACKn <= 1'b1;
        wcnt   <= WAIT_INIT;
      end else begin
        if (cpu_cen && !done) wcnt <= wcnt - 3'd1;
        if (!sel) begin
          DTACKn <= 1'b0;
        end else if (DTACKn) begin
          // Once acked, later bus_ok activity is irrelevant to this cycle.
          if (busy && done) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNTW'(1);
          end else if (!busy && done) begin
            DTACKn <= 1'b0;
          end else if (recover) begin
            DTACKn   <= 1'b0;
            fail_cnt <= fail_cnt - CNTW'(1);
          end
        end
      end
      if (frame) begin
        last_fail <= fail_cnt;
        fail_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dtack_ctrl.sv
// Self-checking bench for jtframe_dtack_ctrl: a 16-bit and a 4-bit counter instance
// share stimulus and are compared against a per-bus-cycle arithmetic model.
module tb_jtframe_dtack_ctrl;
  localparam int NCH = 2;
  localparam int MW  = 2;
`ifdef JTFRAME_DTACK_RECOVER_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, cpu_cen, ASn, frame;
  logic [NCH-1:0] bus_cs, bus_ok;
  logic           dtack16, dtack4;
  logic [15:0]    fail16, last16;
  logic [3:0]     fail4, last4;

  int n_cmp = 0;
  int n_err = 0;
  int mfail[2];
  int mlast[2];
  int maxv[2] = '{65535, 15};

  always #5 clk = ~clk;

  jtframe_dtack_ctrl #(.NCH(NCH), .MINWAIT(MW), .CNTW(16)) dut16 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .ASn(ASn), .bus_cs(bus_cs),
    .bus_ok(bus_ok), .frame(frame), .DTACKn(dtack16), .fail_cnt(fail16),
    .last_fail(last16)
  );

  jtframe_dtack_ctrl #(.NCH(NCH), .MINWAIT(MW), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .ASn(ASn), .bus_cs(bus_cs),
    .bus_ok(bus_ok), .frame(frame), .DTACKn(dtack4), .fail_cnt(fail4),
    .last_fail(last4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int sat(input int v, input int i);
    return (v > maxv[i]) ? maxv[i] : v;
  endfunction

  // First edge k>=2 at which at least 'need' cpu_cen ticks happened on edges 2..k-1.
  function automatic int first_edge(input int need, input int p, input int ph);
    int cnt = 0;
    for (int k = 2; k < 200; k++) begin
      if (cnt >= need) return k;
      if (k % p == ph) cnt++;
    end
    return 200;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_fail16"}, 32'(fail16), 32'(mfail[0]));
    check({tag, "_last16"}, 32'(last16), 32'(mlast[0]));
    check({tag, "_fail4"},  32'(fail4),  32'(mfail[1]));
    check({tag, "_last4"},  32'(last4),  32'(mlast[1]));
  endtask

  task automatic idle_frame();
    @(negedge clk);
    ASn = 1'b1; frame = 1'b1; bus_cs = NCH'($urandom); cpu_cen = 1'($urandom);
    @(negedge clk);
    frame = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mlast[i] = mfail[i];
      mfail[i] = 0;
    end
    check_counters("frame_idle");
  endtask

  // One bus cycle: edge 1 is the cycle start, bus_ok turns ready from edge r,
  // cpu_cen is high on edges with k%p==ph, frame pulses on edge f (0 = none, f>=t0).
  task automatic run_cycle(input logic [NCH-1:0] cs, input int r, input int p,
                           input int ph, input int f, input int lmin);
    int t0, t1, l;
    int ack[2];
    int nfail[2];
    int nlast[2];
    logic [NCH-1:0] ok_pre, ok_post;
    t0 = first_edge(MW, p, ph);
    t1 = first_edge(MW - 1, p, ph);
    for (int i = 0; i < 2; i++) begin
      int  s;
      bit  rec;
      int  a;
      rec = REC && (cs != 0) && (mfail[i] != 0) && (imax(t1, r) < t0);
      nlast[i] = mlast[i];
      s = 0;
      if (cs == 0) begin
        ack[i] = 2; nfail[i] = mfail[i];
      end else if (rec) begin
        ack[i] = imax(t1, r); nfail[i] = mfail[i] - 1;
      end else begin
        ack[i] = imax(t0, r); s = imax(0, r - t0); nfail[i] = sat(mfail[i] + s, i);
      end
      if (f != 0) begin
        if (cs == 0 || rec) begin
          nlast[i] = nfail[i];
          nfail[i] = 0;
        end else begin
          a = imax(0, ((r < f) ? r : f) - t0);
          nlast[i] = sat(mfail[i] + a, i);
          nfail[i] = sat(imax(0, r - 1 - f), i);
        end
      end
    end
    l = imax(imax(lmin, imax(ack[0], ack[1]) + 1), f + 1);
    ok_pre  = NCH'($urandom) & ~(cs & (~cs + NCH'(1)));
    ok_post = NCH'($urandom) | cs;
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      if (k > 1) begin
        check("dtack16", 32'(dtack16), ((k - 1) >= ack[0]) ? 0 : 1);
        check("dtack4",  32'(dtack4),  ((k - 1) >= ack[1]) ? 0 : 1);
      end
      ASn = 1'b0; bus_cs = cs; bus_ok = (k >= r) ? ok_post : ok_pre;
      cpu_cen = (k % p == ph); frame = (k == f);
    end
    @(negedge clk);
    check("dtack16_end", 32'(dtack16), 0);
    check("dtack4_end",  32'(dtack4),  0);
    ASn = 1'b1; frame = 1'b0; bus_cs = NCH'($urandom); cpu_cen = 1'($urandom);
    @(negedge clk);
    check("dtack16_rise", 32'(dtack16), 1);
    check("dtack4_rise",  32'(dtack4),  1);
    for (int i = 0; i < 2; i++) begin
      mfail[i] = nfail[i];
      mlast[i] = nlast[i];
    end
    check_counters("cycle");
  endtask

  initial begin
    int p, ph;
    rst = 1'b1; ASn = 1'b1; frame = 1'b0; cpu_cen = 1'b0; bus_cs = '0; bus_ok = '0;
    mfail = '{0, 0};
    mlast = '{0, 0};
    repeat (3) @(negedge clk);
    check("rst_dtack16", 32'(dtack16), 1);
    check("rst_dtack4",  32'(dtack4),  1);
    check_counters("rst");
    rst = 1'b0;
    @(negedge clk);

    // Unselected access held low for 10 clks.
    run_cycle(2'b00, 1, 2, 0, 0, 10);
    // Minimum wait with cpu_cen every 2nd clk, no stall.
    run_cycle(2'b01, 1, 2, 0, 0, 0);
    // Channel 1 stalls 5 clks past the minimum wait.
    run_cycle(2'b10, first_edge(MW, 2, 0) + 5, 2, 0, 0, 0);
    check("stall5_fail16", 32'(fail16), 5);

    // Three lost clks, then four clean cycles.
    idle_frame();
    run_cycle(2'b01, first_edge(MW, 1, 0) + 3, 1, 0, 0, 0);
    for (int c = 0; c < 4; c++) run_cycle(2'b01, 1, 1, 0, 0, 0);
    check("recover_fail16", 32'(fail16), REC ? 0 : 3);

    // ASn rises on the clk that would have acked: DTACKn never falls.
    @(negedge clk); ASn = 1'b0; bus_cs = 2'b00;
    @(negedge clk); check("rise_win_e1", 32'(dtack16), 1); ASn = 1'b1;
    @(negedge clk); check("rise_win_e2", 32'(dtack16), 1);
    @(negedge clk); check("rise_win_e3", 32'(dtack16), 1);

    // Frame on the same clk as a stall increment.
    idle_frame();
    run_cycle(2'b01, first_edge(MW, 1, 0) + 7, 1, 0, 0, 0);
    run_cycle(2'b01, first_edge(MW, 1, 0) + 1, 1, 0, first_edge(MW, 1, 0), 0);
    check("frame_inc_last16", 32'(last16), 7);
    check("frame_inc_fail16", 32'(fail16), 0);

    // 20-clk stall saturates the 4-bit counter.
    idle_frame();
    run_cycle(2'b10, first_edge(MW, 1, 0) + 20, 1, 0, 0, 0);
    check("sat_fail4", 32'(fail4), 15);

    // Reset mid-cycle with DTACKn low and counters nonzero.
    run_cycle(2'b01, first_edge(MW, 1, 0) + 4, 1, 0, 0, 0);
    idle_frame();
    run_cycle(2'b01, first_edge(MW, 1, 0) + 4, 1, 0, 0, 0);
    @(negedge clk); ASn = 1'b0; bus_cs = 2'b00;
    @(negedge clk);
    @(negedge clk); check("pre_rst_dtack", 32'(dtack16), 0); rst = 1'b1;
    @(negedge clk);
    mfail = '{0, 0};
    mlast = '{0, 0};
    check("mid_rst_dtack16", 32'(dtack16), 1);
    check("mid_rst_dtack4",  32'(dtack4),  1);
    check_counters("mid_rst");
    rst = 1'b0;
    @(negedge clk); check("post_rst_start", 32'(dtack16), 1);
    @(negedge clk); check("post_rst_ack", 32'(dtack16), 0); ASn = 1'b1;
    @(negedge clk); check("post_rst_rise", 32'(dtack16), 1);

    // Randomized bus cycles with occasional idle frame pulses.
    for (int c = 0; c < 40; c++) begin
      p  = $urandom_range(1, 3);
      ph = $urandom_range(0, p - 1);
      run_cycle(NCH'($urandom), $urandom_range(1, 12), p, ph, 0, 0);
      if ($urandom_range(0, 4) == 0) idle_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
